// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcode classes, condition codes and bus selects for ctrl_fsm_gen
// ST_IRQ and OPC_RTI are only produced when CTRL_IRQ_EN is defined.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH0, ST_FETCH1, ST_DECODE, ST_OPND0,
    ST_OPND1, ST_MEMRD, ST_MEMWR, ST_EXEC
`ifdef CTRL_IRQ_EN
    , ST_IRQ
`endif
  } state_t;

  typedef enum logic [2:0] {
    OPC_NOP, OPC_LDI, OPC_LD, OPC_ST, OPC_ALU, OPC_BR, OPC_RTI, OPC_ILL
  } opc_t;

  localparam logic [3:0] CC_ALWAYS = 4'd0;
  localparam logic [3:0] CC_CC     = 4'd1;
  localparam logic [3:0] CC_CS     = 4'd2;
  localparam logic [3:0] CC_NE     = 4'd3;
  localparam logic [3:0] CC_EQ     = 4'd4;
  localparam logic [3:0] CC_PL     = 4'd5;
  localparam logic [3:0] CC_MI     = 4'd6;
  localparam logic [3:0] CC_VC     = 4'd7;
  localparam logic [3:0] CC_VS     = 4'd8;

  localparam int         BUS1_PC   = 0;
  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

  // flags arrive as {C,Z,N,V}
  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] flags);
    logic f_c, f_z, f_n, f_v;
    {f_c, f_z, f_n, f_v} = flags;
    case (cc)
      CC_ALWAYS: cond_true = 1'b1;
      CC_CC:     cond_true = !f_c;
      CC_CS:     cond_true = f_c;
      CC_NE:     cond_true = !f_z;
      CC_EQ:     cond_true = f_z;
      CC_PL:     cond_true = !f_n;
      CC_MI:     cond_true = f_n;
      CC_VC:     cond_true = !f_v;
      CC_VS:     cond_true = f_v;
      default:   cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode class, register index, legality and branch condition
// 0x0F decodes as RTI only when CTRL_IRQ_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = 2
) (
  input  logic [7:0] i_ir,
  input  logic [3:0] i_ccr,
  output logic [2:0] o_opc,
  output logic [1:0] o_reg,
  output logic       o_taken
);

  opc_t w_opc;
  logic w_reg_ok;

  assign o_reg    = i_ir[3:2];
  assign w_reg_ok = (int'(i_ir[3:2]) < NUM_REGS);

  always_comb begin
    w_opc = OPC_ILL;
    case (i_ir[7:4])
      4'h0: begin
        if (i_ir[3:0] == 4'h0) w_opc = OPC_NOP;
`ifdef CTRL_IRQ_EN
        if (i_ir[3:0] == 4'hF) w_opc = OPC_RTI;
`endif
      end
      4'h1:       if (w_reg_ok) w_opc = OPC_LDI;
      4'h2:       if (w_reg_ok) w_opc = OPC_LD;
      4'h3:       if (w_reg_ok) w_opc = OPC_ST;
      4'h4, 4'h5: if (w_reg_ok) w_opc = OPC_ALU;
      4'h6:       if (i_ir[3:0] <= CC_VS) w_opc = OPC_BR;
      default:    w_opc = OPC_ILL;
    endcase
  end

  assign o_opc   = w_opc;
  assign o_taken = cond_true(i_ir[3:0], i_ccr);

endmodule

// File: rtl/ctrl_fsm_gen.sv
// rtl/ctrl_fsm_gen.sv - fetch/decode/execute sequencer with ready-handshaked memory accesses
// CTRL_IRQ_EN adds interrupt entry (irq/irq_ack/epc_load/vec_load) and RTI (pc_restore).
module ctrl_fsm_gen
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = 2,
  parameter int BUS1_W   = 2,
  parameter int ALU_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          i_ir,
  input  logic [3:0]          i_ccr,
  input  logic                i_mem_ready,
`ifdef CTRL_IRQ_EN
  input  logic                i_irq,
  output logic                o_irq_ack,
  output logic                o_epc_load,
  output logic                o_vec_load,
  output logic                o_pc_restore,
`endif
  output logic                o_ir_load,
  output logic                o_mar_load,
  output logic                o_pc_load,
  output logic                o_pc_inc,
  output logic                o_ccr_load,
  output logic [NUM_REGS-1:0] o_reg_load,
  output logic [ALU_W-1:0]    o_alu_sel,
  output logic [BUS1_W-1:0]   o_bus1_sel,
  output logic [1:0]          o_bus2_sel,
  output logic                o_mem_rd,
  output logic                o_mem_wr,
  output logic                o_illegal
);

  state_t r_state;
  state_t w_next;

  logic [2:0]          w_opc;
  logic [1:0]          w_reg;
  logic                w_taken;
  logic [NUM_REGS-1:0] w_reg_hot;
  logic [BUS1_W-1:0]   w_bus1_reg;

  logic                w_ir_load, w_mar_load, w_pc_load, w_pc_inc, w_ccr_load;
  logic [NUM_REGS-1:0] w_reg_load;
  logic [ALU_W-1:0]    w_alu_sel;
  logic [BUS1_W-1:0]   w_bus1_sel;
  logic [1:0]          w_bus2_sel;
  logic                w_mem_rd, w_mem_wr, w_illegal;
`ifdef CTRL_IRQ_EN
  logic                w_irq_ack, w_epc_load, w_vec_load, w_pc_restore;
`endif

  ctrl_decode #(.NUM_REGS(NUM_REGS)) u_decode (
    .i_ir    (i_ir),
    .i_ccr   (i_ccr),
    .o_opc   (w_opc),
    .o_reg   (w_reg),
    .o_taken (w_taken)
  );

  assign w_reg_hot  = NUM_REGS'(1) << w_reg;
  assign w_bus1_reg = BUS1_W'({1'b0, w_reg} + 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_FETCH0;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ir_load  = 1'b0;
    w_mar_load = 1'b0;
    w_pc_load  = 1'b0;
    w_pc_inc   = 1'b0;
    w_ccr_load = 1'b0;
    w_reg_load = '0;
    w_alu_sel  = '0;
    w_bus1_sel = BUS1_W'(BUS1_PC);
    w_bus2_sel = BUS2_ALU;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_illegal  = 1'b0;
`ifdef CTRL_IRQ_EN
    w_irq_ack    = 1'b0;
    w_epc_load   = 1'b0;
    w_vec_load   = 1'b0;
    w_pc_restore = 1'b0;
`endif
    case (r_state)
      ST_FETCH0: begin
        w_bus2_sel = BUS2_BUS1;
        w_mar_load = 1'b1;
        w_next     = ST_FETCH1;
`ifdef CTRL_IRQ_EN
        // irq is only looked at here so an instruction is never split
        if (i_irq) begin
          w_bus2_sel = BUS2_ALU;
          w_mar_load = 1'b0;
          w_next     = ST_IRQ;
        end
`endif
      end
      ST_FETCH1: begin
        w_mem_rd = 1'b1;
        if (i_mem_ready) begin
          w_pc_inc   = 1'b1;
          w_ir_load  = 1'b1;
          w_bus2_sel = BUS2_MEM;
          w_next     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_opc)
          OPC_NOP:                         w_next = ST_FETCH0;
          OPC_LDI, OPC_LD, OPC_ST, OPC_BR: w_next = ST_OPND0;
          OPC_ALU:                         w_next = ST_EXEC;
`ifdef CTRL_IRQ_EN
          OPC_RTI: begin
            w_pc_restore = 1'b1;
            w_next       = ST_FETCH0;
          end
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = ST_FETCH0;
          end
        endcase
      end
      ST_OPND0: begin
        w_bus2_sel = BUS2_BUS1;
        w_mar_load = 1'b1;
        w_next     = ST_OPND1;
      end
      ST_OPND1: begin
        w_mem_rd = 1'b1;
        if (i_mem_ready) begin
          w_bus2_sel = BUS2_MEM;
          w_next     = ST_FETCH0;
          case (w_opc)
            OPC_LDI: begin
              w_reg_load = w_reg_hot;
              w_pc_inc   = 1'b1;
            end
            OPC_LD, OPC_ST: begin
              w_mar_load = 1'b1;
              w_pc_inc   = 1'b1;
              w_next     = (w_opc == OPC_LD) ? ST_MEMRD : ST_MEMWR;
            end
            OPC_BR: begin
              w_pc_load = w_taken;
              w_pc_inc  = !w_taken;
            end
            default: w_next = ST_FETCH0;
          endcase
        end
      end
      ST_MEMRD: begin
        w_mem_rd = 1'b1;
        if (i_mem_ready) begin
          w_bus2_sel = BUS2_MEM;
          w_reg_load = w_reg_hot;
          w_next     = ST_FETCH0;
        end
      end
      ST_MEMWR: begin
        w_bus1_sel = w_bus1_reg;
        w_mem_wr   = 1'b1;
        if (i_mem_ready) w_next = ST_FETCH0;
      end
      ST_EXEC: begin
        w_bus1_sel = w_bus1_reg;
        w_bus2_sel = BUS2_ALU;
        w_alu_sel  = ALU_W'({i_ir[4], i_ir[1:0]});
        w_reg_load = w_reg_hot;
        w_ccr_load = 1'b1;
        w_next     = ST_FETCH0;
      end
`ifdef CTRL_IRQ_EN
      ST_IRQ: begin
        w_irq_ack  = 1'b1;
        w_epc_load = 1'b1;
        w_vec_load = 1'b1;
        w_next     = ST_FETCH0;
      end
`endif
      default: w_next = ST_FETCH0;
    endcase
  end

  // reset forces every strobe low at once, even mid-access
  assign o_ir_load  = reset & w_ir_load;
  assign o_mar_load = reset & w_mar_load;
  assign o_pc_load  = reset & w_pc_load;
  assign o_pc_inc   = reset & w_pc_inc;
  assign o_ccr_load = reset & w_ccr_load;
  assign o_reg_load = reset ? w_reg_load : '0;
  assign o_alu_sel  = reset ? w_alu_sel  : '0;
  assign o_bus1_sel = reset ? w_bus1_sel : '0;
  assign o_bus2_sel = reset ? w_bus2_sel : '0;
  assign o_mem_rd   = reset & w_mem_rd;
  assign o_mem_wr   = reset & w_mem_wr;
  assign o_illegal  = reset & w_illegal;
`ifdef CTRL_IRQ_EN
  assign o_irq_ack    = reset & w_irq_ack;
  assign o_epc_load   = reset & w_epc_load;
  assign o_vec_load   = reset & w_vec_load;
  assign o_pc_restore = reset & w_pc_restore;
`endif

endmodule

// File: tb/tb_ctrl_fsm_gen.sv
// tb/tb_ctrl_fsm_gen.sv - self-checking bench for ctrl_fsm_gen (vector table, random model, corner sequences)
// Also exercises the interrupt path when CTRL_IRQ_EN is defined.
module tb_ctrl_fsm_gen;

  localparam int NR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] i_ir = 8'h00;
  logic [3:0] i_ccr = 4'h0;
  logic       i_mem_ready = 1'b0;
  logic       o_ir_load, o_mar_load, o_pc_load, o_pc_inc, o_ccr_load;
  logic [NR-1:0] o_reg_load;
  logic [2:0] o_alu_sel;
  logic [1:0] o_bus1_sel;
  logic [1:0] o_bus2_sel;
  logic       o_mem_rd, o_mem_wr, o_illegal;
`ifdef CTRL_IRQ_EN
  logic       i_irq = 1'b0;
  logic       o_irq_ack, o_epc_load, o_vec_load, o_pc_restore;
`endif

  always #5 clk = ~clk;

  ctrl_fsm_gen #(.NUM_REGS(NR), .BUS1_W(2), .ALU_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_ir         (i_ir),
    .i_ccr        (i_ccr),
    .i_mem_ready  (i_mem_ready),
`ifdef CTRL_IRQ_EN
    .i_irq        (i_irq),
    .o_irq_ack    (o_irq_ack),
    .o_epc_load   (o_epc_load),
    .o_vec_load   (o_vec_load),
    .o_pc_restore (o_pc_restore),
`endif
    .o_ir_load    (o_ir_load),
    .o_mar_load   (o_mar_load),
    .o_pc_load    (o_pc_load),
    .o_pc_inc     (o_pc_inc),
    .o_ccr_load   (o_ccr_load),
    .o_reg_load   (o_reg_load),
    .o_alu_sel    (o_alu_sel),
    .o_bus1_sel   (o_bus1_sel),
    .o_bus2_sel   (o_bus2_sel),
    .o_mem_rd     (o_mem_rd),
    .o_mem_wr     (o_mem_wr),
    .o_illegal    (o_illegal)
  );

  logic [31:0] all_outs;
`ifdef CTRL_IRQ_EN
  assign all_outs = 32'({o_ir_load, o_mar_load, o_pc_load, o_pc_inc, o_ccr_load, o_reg_load,
                         o_alu_sel, o_bus1_sel, o_bus2_sel, o_mem_rd, o_mem_wr, o_illegal,
                         o_irq_ack, o_epc_load, o_vec_load, o_pc_restore});
`else
  assign all_outs = 32'({o_ir_load, o_mar_load, o_pc_load, o_pc_inc, o_ccr_load, o_reg_load,
                         o_alu_sel, o_bus1_sel, o_bus2_sel, o_mem_rd, o_mem_wr, o_illegal});
`endif

  typedef struct packed {
    int pc_inc; int pc_load; int reg_cnt; int reg_mask; int mem_rd; int mem_wr;
    int illegal; int ccr_load; int mar_load; int ir_load; int pc_restore;
  } tally_t;

  typedef struct packed {
    logic [7:0] ir; logic [3:0] ccr; int wf; int wo; int wm; int cyc; tally_t exp;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;
  int wq[$];
  bit in_acc = 1'b0;
  int wait_left = 0;
  vec_t tv[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic tally_t mk(input int pi, input int pl, input int rm, input int mr, input int mw,
                                input int ml, input int il, input int cl, input int pr);
    tally_t t;
    t = '0;
    t.pc_inc = pi; t.pc_load = pl; t.reg_mask = rm; t.reg_cnt = (rm != 0) ? 1 : 0;
    t.mem_rd = mr; t.mem_wr = mw; t.mar_load = ml; t.illegal = il; t.ccr_load = cl;
    t.ir_load = 1; t.pc_restore = pr;
    return t;
  endfunction

  task automatic addv(input logic [7:0] ir, input logic [3:0] ccr, input int wf, input int wo,
                      input int wm, input int cyc, input tally_t e);
    vec_t v;
    v.ir = ir; v.ccr = ccr; v.wf = wf; v.wo = wo; v.wm = wm; v.cyc = cyc; v.exp = e;
    tv.push_back(v);
  endtask

  // Instruction-level reference: totals of each strobe over one instruction and its length
  task automatic model(input logic [7:0] ir, input logic [3:0] ccr, input int wf, input int wo,
                       input int wm, output int cyc, output tally_t t);
    int hi, lo, r, flag;
    bit ok, taken;
    hi = int'(ir[7:4]); lo = int'(ir[3:0]); r = int'(ir[3:2]); ok = (r < NR);
    t = '0;
    cyc = wf + 3;
    t.mar_load = 1; t.ir_load = 1; t.pc_inc = 1; t.mem_rd = wf + 1;
    if (ir == 8'h00) return;
`ifdef CTRL_IRQ_EN
    if (ir == 8'h0F) begin t.pc_restore = 1; return; end
`endif
    if (hi >= 1 && hi <= 3 && ok) begin
      cyc += 2 + wo; t.mar_load += 1; t.mem_rd += wo + 1; t.pc_inc += 1;
      if (hi == 1) begin
        t.reg_mask = 1 << r; t.reg_cnt = 1;
      end else begin
        cyc += wm + 1; t.mar_load += 1;
        if (hi == 2) begin
          t.mem_rd += wm + 1; t.reg_mask = 1 << r; t.reg_cnt = 1;
        end else t.mem_wr = wm + 1;
      end
    end else if ((hi == 4 || hi == 5) && ok) begin
      cyc += 1; t.reg_mask = 1 << r; t.reg_cnt = 1; t.ccr_load = 1;
    end else if (hi == 6 && lo <= 8) begin
      if (lo == 0) taken = 1'b1;
      else begin
        flag = int'(ccr[3 - (lo - 1) / 2]);
        taken = (lo % 2 == 1) ? (flag == 0) : (flag == 1);
      end
      cyc += 2 + wo; t.mar_load += 1; t.mem_rd += wo + 1;
      if (taken) t.pc_load = 1; else t.pc_inc += 1;
    end else begin
      t.illegal = 1;
    end
  endtask

  // One clock: answer the memory, sample at the falling edge, return just after the rising edge
  task automatic cycle(input logic [7:0] ir, inout tally_t t, inout int viol);
    bit strobe;
    int r;
    r = int'(ir[3:2]);
    strobe = o_mem_rd | o_mem_wr;
    if (strobe) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        wait_left = (wq.size() > 0) ? wq.pop_front() : 0;
      end
      i_mem_ready = (wait_left == 0);
    end else begin
      i_mem_ready = 1'($urandom_range(0, 1));
    end
    #1;
    @(negedge clk);
    t.pc_inc += int'(o_pc_inc);  t.pc_load += int'(o_pc_load);
    t.mem_rd += int'(o_mem_rd);  t.mem_wr += int'(o_mem_wr);
    t.illegal += int'(o_illegal); t.ccr_load += int'(o_ccr_load);
    t.mar_load += int'(o_mar_load); t.ir_load += int'(o_ir_load);
    t.reg_mask |= int'(o_reg_load);
    t.reg_cnt += (o_reg_load != '0) ? 1 : 0;
`ifdef CTRL_IRQ_EN
    t.pc_restore += int'(o_pc_restore);
`endif
    if (o_pc_load && o_pc_inc) viol++;
    if (o_mem_rd && o_mem_wr) viol++;
    if (o_mem_wr && int'(o_bus1_sel) != r + 1) viol++;
    if (o_ccr_load && (o_alu_sel != {ir[4], ir[1:0]} || o_bus2_sel != 2'd0 || int'(o_bus1_sel) != r + 1)) viol++;
    if (o_reg_load != '0 && !(o_bus2_sel == 2'd2 && i_mem_ready) && !(o_bus2_sel == 2'd0 && o_ccr_load)) viol++;
    if (o_ir_load && !(o_bus2_sel == 2'd2 && i_mem_ready)) viol++;
    if (o_illegal && strobe) viol++;
    if (strobe) begin
      if (i_mem_ready) in_acc = 1'b0;
      else wait_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] ir, input logic [3:0] ccr, input int wf, input int wo,
                           input int wm, input int cyc, output tally_t t, output int viol);
    t = '0; viol = 0;
    i_ir = ir; i_ccr = ccr;
    wq.delete(); wq.push_back(wf); wq.push_back(wo); wq.push_back(wm);
    in_acc = 1'b0;
    for (int k = 0; k < cyc; k++) cycle(ir, t, viol);
  endtask

  function automatic int fetch0_sig();
    return (o_mar_load && o_bus1_sel == 2'd0 && o_bus2_sel == 2'd1 && !o_mem_rd && !o_mem_wr) ? 1 : 0;
  endfunction

  task automatic compare_tally(input string tag, input tally_t a, input tally_t e);
    check({tag, ".pc_inc"},   a.pc_inc,   e.pc_inc);
    check({tag, ".pc_load"},  a.pc_load,  e.pc_load);
    check({tag, ".reg_cnt"},  a.reg_cnt,  e.reg_cnt);
    check({tag, ".reg_mask"}, a.reg_mask, e.reg_mask);
    check({tag, ".mem_rd"},   a.mem_rd,   e.mem_rd);
    check({tag, ".mem_wr"},   a.mem_wr,   e.mem_wr);
    check({tag, ".illegal"},  a.illegal,  e.illegal);
    check({tag, ".ccr_load"}, a.ccr_load, e.ccr_load);
    check({tag, ".mar_load"}, a.mar_load, e.mar_load);
    check({tag, ".ir_load"},  a.ir_load,  e.ir_load);
    check({tag, ".pc_restore"}, a.pc_restore, e.pc_restore);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tally_t t, e;
    int viol, cyc, wf, wo, wm;
    logic [7:0] ir;
    logic [3:0] ccr;
    string tag;

    //    ir     ccr    wf wo wm cyc    pi pl rm mr mw ml il cl pr
    addv(8'h11, 4'h0, 0, 0, 0, 5, mk(2, 0, 1, 2, 0, 2, 0, 0, 0));
    addv(8'h24, 4'h0, 0, 0, 3, 9, mk(2, 0, 2, 6, 0, 3, 0, 0, 0));
    addv(8'h62, 4'h8, 0, 0, 0, 5, mk(1, 1, 0, 2, 0, 2, 0, 0, 0));
    addv(8'h62, 4'h0, 0, 0, 0, 5, mk(2, 0, 0, 2, 0, 2, 0, 0, 0));
    addv(8'h3C, 4'h0, 0, 0, 0, 3, mk(1, 0, 0, 1, 0, 1, 1, 0, 0));
    addv(8'h34, 4'h0, 1, 0, 0, 7, mk(2, 0, 0, 3, 1, 3, 0, 0, 0));
    addv(8'h00, 4'h0, 0, 0, 0, 3, mk(1, 0, 0, 1, 0, 1, 0, 0, 0));
    addv(8'h45, 4'h0, 0, 0, 0, 4, mk(1, 0, 2, 1, 0, 1, 0, 1, 0));
    addv(8'h69, 4'hF, 0, 0, 0, 3, mk(1, 0, 0, 1, 0, 1, 1, 0, 0));
`ifdef CTRL_IRQ_EN
    addv(8'h0F, 4'h0, 0, 0, 0, 3, mk(1, 0, 0, 1, 0, 1, 0, 0, 1));
`else
    addv(8'h0F, 4'h0, 0, 0, 0, 3, mk(1, 0, 0, 1, 0, 1, 1, 0, 0));
`endif
    addv(8'h68, 4'h1, 0, 0, 0, 5, mk(1, 1, 0, 2, 0, 2, 0, 0, 0));
    addv(8'h70, 4'h0, 0, 0, 0, 3, mk(1, 0, 0, 1, 0, 1, 1, 0, 0));
    addv(8'h10, 4'h0, 0, 2, 0, 7, mk(2, 0, 1, 4, 0, 2, 0, 0, 0));
    addv(8'h5B, 4'h0, 0, 0, 0, 3, mk(1, 0, 0, 1, 0, 1, 1, 0, 0));
    addv(8'h30, 4'h0, 0, 1, 2, 9, mk(2, 0, 0, 3, 3, 3, 0, 0, 0));

    // reset held: everything low, whatever mem_ready does
    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs_zero", int'(all_outs), 0);
    i_mem_ready = 1'b1;
    #1;
    check("reset.outputs_zero_ready", int'(all_outs), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("reset.release_fetch0", fetch0_sig(), 1);

    foreach (tv[i]) begin
      run_instr(tv[i].ir, tv[i].ccr, tv[i].wf, tv[i].wo, tv[i].wm, tv[i].cyc, t, viol);
      tag = $sformatf("vec%0d_ir%02h", i, tv[i].ir);
      compare_tally(tag, t, tv[i].exp);
      check({tag, ".invariants"}, viol, 0);
      check({tag, ".back_to_fetch0"}, fetch0_sig(), 1);
    end

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
      else ir = {4'($urandom_range(0, 6)), 4'($urandom)};
      ccr = 4'($urandom);
      wf = $urandom_range(0, 3); wo = $urandom_range(0, 3); wm = $urandom_range(0, 3);
      model(ir, ccr, wf, wo, wm, cyc, e);
      run_instr(ir, ccr, wf, wo, wm, cyc, t, viol);
      tag = $sformatf("rnd%0d_ir%02h", n, ir);
      compare_tally(tag, t, e);
      check({tag, ".invariants"}, viol, 0);
      check({tag, ".back_to_fetch0"}, fetch0_sig(), 1);
    end

    // reset arriving while a store waits on a slow memory
    i_ir = 8'h34; i_ccr = 4'h0; t = '0; viol = 0; in_acc = 1'b0;
    wq.delete(); wq.push_back(0); wq.push_back(0); wq.push_back(20);
    repeat (5) cycle(8'h34, t, viol);
    check("memwr.active", int'(o_mem_wr), 1);
    repeat (2) cycle(8'h34, t, viol);
    check("memwr.still_waiting", int'(o_mem_wr), 1);
    check("memwr.bus1_reg", int'(o_bus1_sel), 2);
    #2 reset = 1'b0;
    #1;
    check("memwr.reset_drops_mem_wr", int'(o_mem_wr), 0);
    check("memwr.reset_all_zero", int'(all_outs), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    in_acc = 1'b0; wq.delete(); i_mem_ready = 1'b0;
    #1;
    check("memwr.after_release_fetch0", fetch0_sig(), 1);

`ifdef CTRL_IRQ_EN
    i_ir = 8'h00; i_irq = 1'b1;
    #1;
    check("irq.fetch0_no_ack", int'(o_irq_ack), 0);
    @(posedge clk);
    #1 i_irq = 1'b0;
    #1;
    check("irq.ack_epc_vec_noinc", int'({o_irq_ack, o_epc_load, o_vec_load, o_pc_inc}), 14);
    @(posedge clk);
    #1;
    check("irq.ack_one_cycle", int'(o_irq_ack), 0);
    check("irq.back_to_fetch0", fetch0_sig(), 1);
    run_instr(8'h0F, 4'h0, 0, 0, 0, 3, t, viol);
    check("rti.pc_restore", t.pc_restore, 1);
    check("rti.no_illegal", t.illegal, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
